// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the round-robin FIFO write arbiter.
// The arbiter uses the master modport; requesters/FIFO model use the slave modport.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int OWNER_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            ack;
   logic                          fifo_full;
   logic                          fifo_cs;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_data_in;
   logic                          busy;
   logic [OWNER_W-1:0]            owner;

   modport master (
      input  req, req_data, fifo_full,
      output gnt, ack, fifo_cs, fifo_wr_en, fifo_data_in, busy, owner
   );

   modport slave (
      output req, req_data, fifo_full,
      input  gnt, ack, fifo_cs, fifo_wr_en, fifo_data_in, busy, owner
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port between NUM_REQ requesters;
// each grant allows a burst of up to BURST_LEN words, then ownership rotates.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4
) (
   input logic               clk,
   input logic               rst,
   fifo_wr_arbiter_if.master bus
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BURST_LEN + 1);

   typedef enum logic {ST_ARB, ST_BURST} state_t;

   state_t             r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_busy;
   logic [OW-1:0]      r_owner;
   logic [OW-1:0]      r_ptr;
   logic [CW-1:0]      r_cnt;

   logic                  w_found;
   logic [OW-1:0]         w_pick;
   logic [OW-1:0]         w_idx;
   logic                  w_write;
   logic                  w_last;
   logic                  w_release;
   logic [OW-1:0]         w_ptr_next;
   logic [DATA_WIDTH-1:0] w_data;

   // Scan from r_ptr upward; iterating downward lets the nearest requester overwrite farther ones.
   // NOTE: combinational blocks use blocking '=' and assign every output a default first, so
   // no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = OW'((int'(r_ptr) + k) % NUM_REQ);
         if (bus.req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_owner == OW'(i)) w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign w_write    = ~rst & (r_state == ST_BURST) & bus.req[r_owner] & ~bus.fifo_full;
   assign w_last     = w_write & ((r_cnt + CW'(1)) == CW'(BURST_LEN));
   assign w_release  = ~bus.req[r_owner] | w_last;
   assign w_ptr_next = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + OW'(1);

   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ARB;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_found) begin
                  r_state <= ST_BURST;
                  r_gnt   <= NUM_REQ'(1) << w_pick;
                  r_busy  <= 1'b1;
                  r_owner <= w_pick;
                  r_cnt   <= '0;
               end
            end
            ST_BURST: begin
               if (w_write) r_cnt <= r_cnt + CW'(1);
               // A full FIFO with the owner still requesting stalls here indefinitely.
               if (w_release) begin
                  r_state <= ST_ARB;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= w_ptr_next;
               end
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

   assign bus.gnt          = r_gnt;
   assign bus.busy         = r_busy;
   assign bus.owner        = r_owner;
   assign bus.ack          = w_write ? (NUM_REQ'(1) << r_owner) : '0;
   assign bus.fifo_wr_en   = w_write;
   assign bus.fifo_cs      = w_write;
   assign bus.fifo_data_in = w_data;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized phase, all
// compared every cycle against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int BL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Requester side: remaining words, word index, base value, current word, enable.
   int          rem  [N];
   int          nxt  [N];
   logic [DW-1:0] base [N];
   logic [DW-1:0] word [N];
   bit          en   [N];
   bit          rnd_mode = 1'b0;

   // Model: who owns the port, words written in this grant, rotation pointer.
   bit       chk_en = 1'b0;
   bit       m_busy = 1'b0;
   int       m_owner = 0;
   int       m_ptr = 0;
   int       m_words = 0;
   logic [N-1:0] ack_seen = '0;
   logic [N-1:0] e_gnt, e_ack;
   bit       e_wr;
   int       a_port;

   logic [DW-1:0] log_data[$];
   int            log_port[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      logic [N*DW-1:0] d;
      logic [N-1:0]    r;
      for (int i = 0; i < N; i++) begin
         r[i]            = en[i] && (rem[i] > 0);
         d[i*DW +: DW]   = word[i];
      end
      bus.req      = r;
      bus.req_data = d;
   endtask

   task automatic load(input int i, input int n, input logic [DW-1:0] b);
      rem[i]  = n;
      nxt[i]  = 0;
      base[i] = b;
      word[i] = b;
      en[i]   = 1'b1;
   endtask

   // One clock: requesters that were acked at this edge move on to their next word.
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (ack_seen[i]) begin
            rem[i]--;
            nxt[i]++;
            word[i] = rnd_mode ? $urandom : base[i] + DW'(nxt[i]);
         end
      end
      drive();
   endtask

   // Compare process: expected outputs from the model, then advance the model past the edge.
   always @(negedge clk) begin
      if (chk_en) begin
         e_wr  = !rst && m_busy && bus.req[m_owner] && !bus.fifo_full;
         e_gnt = m_busy ? (N'(1) << m_owner) : '0;
         e_ack = e_wr ? e_gnt : '0;
         check("gnt",   bus.gnt,        e_gnt);
         check("busy",  bus.busy,       m_busy);
         check("owner", bus.owner,      m_owner);
         check("wr_en", bus.fifo_wr_en, e_wr);
         check("cs",    bus.fifo_cs,    e_wr);
         check("ack",   bus.ack,        e_ack);
         if (e_wr) check("data", bus.fifo_data_in, word[m_owner]);
         if (bus.fifo_wr_en === 1'b1) begin
            a_port = -1;
            for (int i = 0; i < N; i++) if (bus.ack[i] === 1'b1) a_port = i;
            log_data.push_back(bus.fifo_data_in);
            log_port.push_back(a_port);
         end
         ack_seen = e_ack;
         if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_words = 0;
         end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
               if (!m_busy && bus.req[(m_ptr + k) % N]) begin
                  m_busy = 1; m_owner = (m_ptr + k) % N; m_words = 0;
               end
            end
         end else begin
            if (e_wr) m_words++;
            if (!bus.req[m_owner] || m_words == BL) begin
               m_busy = 0;
               m_ptr  = (m_owner + 1) % N;
            end
         end
      end else begin
         ack_seen = '0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp2_d[12];
      int exp2_p[12];
      int ng;
      exp2_d = '{100, 101, 102, 103, 200, 201, 202, 203, 104, 105, 106, 107};
      exp2_p = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; nxt[i] = 0; base[i] = '0; word[i] = '0; en[i] = 1'b0;
      end
      bus.fifo_full = 1'b0;
      rst = 1'b1;
      drive();
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      step();
      check("rst_gnt",   bus.gnt,   0);
      check("rst_busy",  bus.busy,  0);
      check("rst_owner", bus.owner, 0);
      rst = 1'b0;

      // Single requester, three words, early release.
      log_data.delete(); log_port.delete();
      load(2, 3, 10); drive();
      repeat (8) step();
      check("s1_nwr", log_data.size(), 3);
      for (int k = 0; k < 3 && k < log_data.size(); k++) begin
         check("s1_data", log_data[k], 10 + k);
         check("s1_port", log_port[k], 2);
      end
      check("s1_ptr",   m_ptr,     3);
      check("s1_busy",  bus.busy,  0);
      check("s1_owner", bus.owner, 2);

      // Two continuous requesters alternate in bursts of BL.
      log_data.delete(); log_port.delete();
      load(0, 8, 100); load(1, 4, 200); drive();
      repeat (20) step();
      check("s2_nwr", log_data.size(), 12);
      for (int k = 0; k < 12 && k < log_data.size(); k++) begin
         check("s2_data", log_data[k], exp2_d[k]);
         check("s2_port", log_port[k], exp2_p[k]);
      end
      check("s2_ptr", m_ptr, 1);

      // FIFO full stall in the middle of a burst.
      log_data.delete(); log_port.delete();
      load(1, 4, 300); drive();
      for (int c = 0; c < 20 && log_data.size() < 2; c++) step();
      check("s3_pre_nwr", log_data.size(), 2);
      bus.fifo_full = 1'b1;
      repeat (5) step();
      check("s3_stall_nwr", log_data.size(), 2);
      check("s3_stall_busy", bus.busy, 1);
      check("s3_stall_gnt",  bus.gnt,  4'b0010);
      bus.fifo_full = 1'b0;
      repeat (8) step();
      check("s3_nwr", log_data.size(), 4);
      for (int k = 0; k < 4 && k < log_data.size(); k++) check("s3_data", log_data[k], 300 + k);
      check("s3_ptr",  m_ptr,    2);
      check("s3_busy", bus.busy, 0);

      // Port 3 releases early; pointer wraps so port 0 beats port 2.
      log_data.delete(); log_port.delete();
      load(3, 1, 400); drive();
      step();
      load(0, 1, 500); load(2, 1, 600); drive();
      repeat (12) step();
      check("s4_nwr", log_data.size(), 3);
      if (log_data.size() >= 3) begin
         check("s4_p0", log_port[0], 3); check("s4_d0", log_data[0], 400);
         check("s4_p1", log_port[1], 0); check("s4_d1", log_data[1], 500);
         check("s4_p2", log_port[2], 2); check("s4_d2", log_data[2], 600);
      end

      // Reset in the middle of a port 2 burst.
      log_data.delete(); log_port.delete();
      load(2, 8, 700); drive();
      for (int c = 0; c < 20 && log_data.size() < 2; c++) step();
      check("s5_pre_nwr", log_data.size(), 2);
      rst = 1'b1;
      load(0, 2, 800); drive();
      #1;
      check("s5_rst_wr_en", bus.fifo_wr_en, 0);
      check("s5_rst_ack",   bus.ack,        0);
      step();
      check("s5_gnt",  bus.gnt,  0);
      check("s5_busy", bus.busy, 0);
      rst = 1'b0;
      repeat (12) step();
      check("s5_nwr_ge5", log_data.size() >= 5, 1);
      if (log_data.size() >= 5) begin
         check("s5_p2", log_port[2], 0); check("s5_d2", log_data[2], 800);
         check("s5_d3", log_data[3], 801);
         check("s5_p4", log_port[4], 2); check("s5_d4", log_data[4], 702);
      end
      repeat (20) step();

      // All four requesting: strict rotation, BL words per grant.
      log_data.delete(); log_port.delete();
      for (int i = 0; i < N; i++) load(i, 1000, DW'((i + 1) * 1000));
      drive();
      repeat (40) step();
      for (int i = 0; i < N; i++) en[i] = 1'b0;
      drive();
      repeat (6) step();
      ng = log_port.size() / BL;
      check("s6_groups", ng, 8);
      for (int g = 0; g < ng; g++)
         for (int j = 0; j < BL; j++)
            check("s6_rotation", log_port[g*BL + j], (3 + g) % N);

      // Randomized traffic, FIFO backpressure, abandons and occasional resets.
      rnd_mode = 1'b1;
      log_data.delete(); log_port.delete();
      for (int i = 0; i < N; i++) rem[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rem[i] <= 0 && $urandom_range(0, 3) == 0) begin
               rem[i] = $urandom_range(1, 10); word[i] = $urandom; en[i] = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) en[i] = !en[i];
         end
         bus.fifo_full = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 199) == 0);
         drive();
         step();
      end
      rst = 1'b0;
      bus.fifo_full = 1'b0;
      drive();
      repeat (5) step();
      check("rnd_activity", log_data.size() > 100, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the synchronous FIFO (fifo_syn) between NUM_REQ requesters.
- A winning requester holds the port for a burst of up to BURST_LEN words. Ownership then rotates to the next requester.
- Sits directly in front of fifo_syn: drives its cs, wr_en and data_in, and honours its full flag.

Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- DATA_WIDTH, 32: word width; must match the FIFO's DATA_WIDTH.
- BURST_LEN, 4: maximum consecutive words written per grant; must be at least 1.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, NUM_REQ: per-requester request; req[i] high means req_data word i is valid.
- req_data, input, NUM_REQ*DATA_WIDTH: flattened data; word i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt, output, NUM_REQ: registered one-hot grant to the current owner; all zero when there is no owner.
- ack, output, NUM_REQ: combinational; ack[i] high means word i is written this cycle.
- fifo_full, input, 1: full flag from the FIFO.
- fifo_cs, output, 1: chip select to the FIFO.
- fifo_wr_en, output, 1: write enable to the FIFO.
- fifo_data_in, output, DATA_WIDTH: write data to the FIFO.
- busy, output, 1: registered; high while in BURST.
- owner, output, clog2(NUM_REQ): index of the current or last owner.

Behaviour:
- Reset values (rst high at a clock edge):
  - state returns to ARB; gnt, busy, owner, burst counter cnt and priority pointer ptr all go to 0.
  - While rst is high, ack, fifo_wr_en and fifo_cs are forced to 0.
- States: ARB and BURST.
- ARB:
  - If req is nonzero, pick the first i with req[i] high, scanning from ptr upward modulo NUM_REQ.
  - Next cycle: state=BURST, gnt one-hot at i, owner=i, cnt=0.
  - If req is zero, stay in ARB. No writes occur in ARB.
- BURST write condition: write = req[owner] & ~fifo_full, evaluated combinationally.
  - fifo_wr_en = write and fifo_cs = write.
  - fifo_data_in = req_data word owner.
  - ack[owner] = write; every other ack bit is 0.
- BURST per-cycle rules:
  - If write is high, cnt increments. If cnt+1 equals BURST_LEN, go to ARB next cycle.
  - If req[owner] is low, go to ARB next cycle (early release).
  - If fifo_full is high while req[owner] is high, stall: no write, cnt held, stay in BURST. There is no timeout.
- On any BURST-to-ARB transition: ptr = (owner+1) mod NUM_REQ, gnt cleared, busy cleared.
- Latency:
  - The first write happens one cycle after req is seen in ARB.
  - Each grant handoff costs exactly one ARB bubble cycle.
- Requester contract:
  - req_data must be stable while req is high.
  - The requester advances to its next word only after it sees ack.
  - Once asserted, req must not drop until acked, except to abandon the request.
- Fairness: a continuously requesting port waits at most (NUM_REQ-1)*(BURST_LEN+1) cycles plus FIFO stall time.
- fifo_wr_en is never high when fifo_full is high.
- Requests from non-owners during BURST are ignored until the next ARB.
- Reset mid-burst: the in-flight word is not written. Arbitration restarts from ptr=0.
- ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Only req[2] held, with words 10, 11, 12 presented on successive acks, then req drops: ARB bubble; fifo_wr_en high for 3 cycles with data 10, 11, 12; ack[2] high in those cycles; return to ARB; ptr=3.
- req[0] and req[1] held continuously, BURST_LEN=4: FIFO receives 4 words from port 0, one bubble, 4 from port 1, one bubble, then port 0 again; gnt alternates 0001 and 0010.
- Port 1 is the owner and fifo_full rises after the 2nd write for 5 cycles: no wr_en and no ack during the stall, cnt holds at 2; after full falls, the remaining 2 words are written and the burst ends.
- Port 3 is the owner and drops req after 1 word: return to ARB next cycle; ptr wraps to 0; pending req[0] wins before req[2].
- rst asserted for 1 cycle in the middle of a port 2 burst while fifo_full=0: fifo_wr_en is 0 that cycle; next cycle gnt=0 and busy=0; after rst is released, port 0 wins if requesting.
- All 4 ports requesting for 40 cycles: each port receives exactly BURST_LEN words per round; fifo_wr_en is never high with fifo_full=1; scoreboard order matches the round-robin sequence.
